// File: rtl/lsp_prev_update.sv
// MA-predictor history update: shifts freq_prev[2..0] into freq_prev[3..1], then
// copies lsp_ele into freq_prev[0]. Each word takes one READ/LATCH/WRITE pass on scratch memory.
module lsp_prev_update #(
  parameter int M      = 10,
  parameter int MA_NP  = 4,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] lspele,
  input  logic [ADDR_W-1:0] freq_prev,
  input  logic [DATA_W-1:0] readIn,
  output logic [ADDR_W-1:0] readRequested,
  output logic [ADDR_W-1:0] writeRequested,
  output logic [DATA_W-1:0] writeOut,
  output logic              memWrite
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [1:0] K_LAST = 2'(MA_NP - 1);
  localparam logic [3:0] J_LAST = 4'(M - 1);

  logic [2:0]        state;
  logic [1:0]        k;
  logic [3:0]        j;
  logic [6:0]        lsp_base;
  logic [4:0]        fp_base;
  logic [DATA_W-1:0] data_q;

  // Only the upper address fields of the base pointers select a block.
  logic unused_base_bits;
  assign unused_base_bits = ^{lspele[3:0], freq_prev[5:0]};

  assign writeOut = data_q;

  // Frame k takes its data from frame k-1; frame 0 takes it from lsp_ele.
  function automatic logic [ADDR_W-1:0] src_addr(input logic [4:0] fb, input logic [6:0] lb,
                                                 input logic [1:0] kk, input logic [3:0] jj);
    if (kk != 2'd0) return {fb, kk - 2'd1, jj};
    else            return {lb, jj};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      k              <= K_LAST;
      j              <= 4'd0;
      lsp_base       <= 7'd0;
      fp_base        <= 5'd0;
      data_q         <= '0;
      readRequested  <= '0;
      writeRequested <= '0;
      memWrite       <= 1'b0;
      done           <= 1'b0;
    end else begin
      done     <= 1'b0;
      memWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lsp_base      <= lspele[10:4];
            fp_base       <= freq_prev[10:6];
            k             <= K_LAST;
            j             <= 4'd0;
            readRequested <= src_addr(freq_prev[10:6], lspele[10:4], K_LAST, 4'd0);
            state         <= READ;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          data_q         <= readIn;
          writeRequested <= {fp_base, k, j};
          memWrite       <= 1'b1;
          state          <= WRITE;
        end
        WRITE: begin
          // Descending k means each source word is read before it is overwritten.
          if (j != J_LAST) begin
            j             <= j + 4'd1;
            readRequested <= src_addr(fp_base, lsp_base, k, j + 4'd1);
            state         <= READ;
          end else if (k != 2'd0) begin
            j             <= 4'd0;
            k             <= k - 2'd1;
            readRequested <= src_addr(fp_base, lsp_base, k - 2'd1, 4'd0);
            state         <= READ;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsp_prev_update.md
Name: lsp_prev_update

Overview:
- Updates the MA-predictor history after LSP composition; this is the stage directly downstream of the LSP previous-compose block.
- Shifts the four-frame freq_prev history in scratch memory (freq_prev[k] <- freq_prev[k-1] for k=3..1), then copies the current lsp_ele vector into freq_prev[0].
- Purely a memory-to-memory mover on the shared 11-bit-address / 32-bit-data scratch memory.
- Started by the Qua_Lsp controller once compose reports done.

Parameters:
- M, 10, LSP order (words per vector).
- MA_NP, 4, MA predictor order (history frames).
- ADDR_W, 11, scratch memory address width.
- DATA_W, 32, scratch memory data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins an update when idle.
- done  out  1  one-cycle pulse when the update is complete.
- lspele  in  11  base address of lsp_ele[0..9]; word j at {lspele[10:4], j[3:0]}.
- freq_prev  in  11  base of history; word [k][j] at {freq_prev[10:6], k[1:0], j[3:0]}.
- readIn  in  32  memory read data; valid one cycle after readRequested is presented.
- readRequested  out  11  memory read address.
- writeRequested  out  11  memory write address.
- writeOut  out  32  memory write data.
- memWrite  out  1  write strobe; one cycle per word.

Behaviour:
- Reset (reset=0, async) values: state=IDLE; done, memWrite, readRequested, writeRequested, writeOut all 0; k=3, j=0.
- Base addresses lspele and freq_prev are sampled on start and held in registers for the whole operation.
- States:
  - IDLE: start=1 -> READ (k=3, j=0); otherwise stay.
  - READ: drive readRequested with the source address -> LATCH.
    - Source for k>=1: freq_prev[k-1][j].
    - Source for k=0: lsp_ele[j].
  - LATCH: capture readIn into an internal data register -> WRITE.
  - WRITE: drive writeRequested=freq_prev[k][j], writeOut=data register, memWrite=1 for this cycle only.
    - If j<M-1: j++ -> READ.
    - Else if k>0: j=0, k-- -> READ.
    - Else -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Copy order is strictly k=3,2,1,0 with j=0..9 inside each k. Descending k guarantees every source word is read before it is overwritten.
- Latency: 40 words x 3 cycles = 120 cycles. If start is sampled at edge 0, done is high in the cycle after edge 120.
- Data is copied bit-exact as a full 32-bit word; no arithmetic and no saturation.
- Address slots j=10..15 and the lsp_ele source words are never written.
- Outside the WRITE state, memWrite=0. writeOut and writeRequested hold their last values.
- start while busy (not IDLE): ignored; the in-flight operation is unaffected.
- start asserted in the DONE cycle: ignored. start in the cycle after done: accepted.
- Reset mid-operation: immediate return to IDLE with reset values. Words already written stay written; there is no rollback.
- j and k counters: 4-bit and 2-bit fields. The k=0 case terminates rather than wrapping.

Test Plan:
- Basic update: lspele=288, freq_prev=320, memory preloaded with fp[k][j]=16'h1000*k+j and lsp_ele[j]=16'h0A00+j, start pulse.
  - Expect fp[3][j]=2000+j, fp[2][j]=1000+j, fp[1][j]=0000+j, fp[0][j]=0A00+j for j=0..9.
  - Expect slots 10..15 and lsp_ele unchanged.
- Timing: start sampled at cycle T -> exactly 40 memWrite pulses; first write address 11'd368 (k=3,j=0); last write address 11'd329 (k=0,j=9); done high at T+121 for one cycle only.
- Ignored start: re-pulse start at T+50 during the update -> write count stays 40, done fires once, memory result identical to the basic case.
- Async reset: assert reset=0 at write #15 -> all outputs 0 within the same cycle, no further writes; a fresh start then completes all 40 words correctly.
- Back-to-back frames: 60 frames driven from ITU G.729 vectors, each running compose then update -> freq_prev contents match the C reference after every frame.
- Full-width data: lsp_ele[j]=32'hFFFF8001 -> fp[0][j] reads back 32'hFFFF8001 exactly.
